// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage.
// One M-extension op at a time, one bit per cycle; busy stalls the front of the
// pipeline while the op runs, and done pulses for one cycle with the result.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   start           ID/EX holds a valid M op
//   funct3          M-op selector (MUL..REMU)
//   op_a, op_b      forwarded rs1/rs2 values
//   reg_waddr       destination register of the op
//   flush           aborts an op in progress
//   busy            unit occupied (PREP/CALC/FIX)
//   done            one-cycle pulse, result/reg_waddr_o valid
//   result          final result
//   reg_waddr_o     destination captured at start
module ex_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      reg_waddr,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      reg_waddr_o
);

    localparam int unsigned CW = $clog2(XLEN);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [2:0]        fn_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [4:0]        waddr_q;
    logic [XLEN-1:0]   opd_q;      // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q;      // product, or {remainder, quotient}
    logic              neg_q;      // sign to apply to the selected result field
    logic [CW-1:0]     cnt_q;

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic              sub_ok;
    logic [2*XLEN-1:0] mul_next, div_next;
    logic [2*XLEN-1:0] mul_full;
    logic [XLEN-1:0]   quo_val, rem_val;
    logic              div0, ovf;
    logic [XLEN-1:0]   fix_val;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic; flush aborts any busy state
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start && !flush) state_next = S_PREP;
            S_PREP: state_next = flush ? S_IDLE : S_CALC;
            S_CALC: begin
                if (flush)              state_next = S_IDLE;
                else if (cnt_q == '0)   state_next = S_FIX;
            end
            S_FIX:  state_next = flush ? S_IDLE : S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Operand signedness and magnitudes; negating MIN_NEG wraps to itself,
    // which is the correct unsigned magnitude 2^(XLEN-1)
    always_comb begin
        a_neg = ((fn_q == F_MULH) || (fn_q == F_MULHSU) || (fn_q == F_DIV) || (fn_q == F_REM))
                && a_q[XLEN-1];
        b_neg = ((fn_q == F_MULH) || (fn_q == F_DIV) || (fn_q == F_REM)) && b_q[XLEN-1];
        a_mag = a_neg ? -a_q : a_q;
        b_mag = b_neg ? -b_q : b_q;
    end

    // One iteration step: shift-add multiply and restoring divide
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : {(XLEN+1){1'b0}});
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        sub_ok   = (rem_sh >= {1'b0, opd_q});
        div_next = sub_ok ? {XLEN'(rem_sh - {1'b0, opd_q}), acc_q[XLEN-2:0], 1'b1}
                          : {acc_q[2*XLEN-2:0], 1'b0};
    end

    // Final sign fix-up, field selection and special cases
    always_comb begin
        mul_full = neg_q ? -acc_q : acc_q;
        quo_val  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_val  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        div0     = (b_q == '0);
        ovf      = ((fn_q == F_DIV) || (fn_q == F_REM)) && (a_q == MIN_NEG) && (b_q == '1);
        fix_val  = '0;
        case (fn_q)
            F_MUL:                     fix_val = mul_full[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU: fix_val = mul_full[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:             fix_val = div0 ? '1 : (ovf ? MIN_NEG : quo_val);
            default:                   fix_val = div0 ? a_q : (ovf ? '0 : rem_val);
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fn_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            waddr_q     <= '0;
            opd_q       <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            result      <= '0;
            reg_waddr_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        fn_q    <= funct3;
                        a_q     <= op_a;
                        b_q     <= op_b;
                        waddr_q <= reg_waddr;
                    end
                end
                S_PREP: begin
                    opd_q <= fn_q[2] ? b_mag : a_mag;
                    acc_q <= {{XLEN{1'b0}}, (fn_q[2] ? a_mag : b_mag)};
                    // Remainder follows the dividend; everything else the XOR of signs
                    neg_q <= (fn_q == F_REM) ? a_neg : (a_neg ^ b_neg);
                    cnt_q <= CW'(XLEN - 1);
                end
                S_CALC: begin
                    acc_q <= fn_q[2] ? div_next : mul_next;
                    cnt_q <= cnt_q - CW'(1);
                end
                S_FIX: begin
                    if (!flush) begin
                        result      <= fix_val;
                        reg_waddr_o <= waddr_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered status outputs, decoded from the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == S_PREP) || (state_next == S_CALC) || (state_next == S_FIX);
            done <= (state_next == S_DONE);
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed bench for ex_muldiv with hand-computed expected values.
module tb_ex_muldiv;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      reg_waddr;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      reg_waddr_o;

    int total = 0;
    int bad   = 0;

    ex_muldiv #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .funct3      (funct3),
        .op_a        (op_a),
        .op_b        (op_b),
        .reg_waddr   (reg_waddr),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .reg_waddr_o (reg_waddr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for done, counting edges and busy cycles seen on the way
    task automatic wait_done(output int edges, output int busy_cyc);
        edges    = 0;
        busy_cyc = 0;
        while (done !== 1'b1 && edges < 200) begin
            if (busy === 1'b1) busy_cyc++;
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa, input logic [31:0] exp, input string tag);
        int edges, bc;
        @(negedge clk);
        funct3 = f; op_a = a; op_b = b; reg_waddr = wa; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(edges, bc);
        check({tag, "_lat"},   32'(edges + 1), 32'(XLEN + 3));
        check({tag, "_busyn"}, 32'(bc), 32'(XLEN + 2));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_res"},   result, exp);
        check({tag, "_waddr"}, 32'(reg_waddr_o), 32'(wa));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int edges, bc, seen;
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = '0; op_a = '0; op_b = '0; reg_waddr = '0;
        #12;
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_res",   result, 32'd0);
        check("rst_waddr", 32'(reg_waddr_o), 32'd0);
        @(negedge clk); rst = 1'b0;

        do_op(3'b000, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, "mul_7_m3");
        do_op(3'b000, 32'h12345678, 32'h10,       5'd2,  32'h23456780, "mul_shift");
        do_op(3'b001, 32'h80000000, 32'h80000000, 5'd3,  32'h40000000, "mulh_min");
        do_op(3'b011, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000, "mulhu_min");
        do_op(3'b010, 32'h80000000, 32'h80000000, 5'd5,  32'hC0000000, "mulhsu_min");
        do_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, "mulhu_max");
        do_op(3'b100, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, "div_m7_2");
        do_op(3'b110, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, "rem_m7_2");
        do_op(3'b101, 32'hFFFFFFFF, 32'd16,       5'd9,  32'h0FFFFFFF, "divu_16");
        do_op(3'b111, 32'd100,      32'd7,        5'd10, 32'd2,        "remu_100_7");
        do_op(3'b100, 32'h12345678, 32'd0,        5'd11, 32'hFFFFFFFF, "div_z");
        do_op(3'b101, 32'h12345678, 32'd0,        5'd12, 32'hFFFFFFFF, "divu_z");
        do_op(3'b110, 32'h12345678, 32'd0,        5'd13, 32'h12345678, "rem_z");
        do_op(3'b111, 32'h12345678, 32'd0,        5'd14, 32'h12345678, "remu_z");
        do_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, "div_ovf");
        do_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000, "rem_ovf");
        do_op(3'b100, 32'hFFFFFFF9, 32'd0,        5'd17, 32'hFFFFFFFF, "div_z_neg");

        // Flush and start together in IDLE: start ignored
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3; reg_waddr = 5'd20;
        start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 32'(busy), 32'd0);

        // Flush at CALC cycle 10: no done, result unchanged
        do_op(3'b000, 32'd6, 32'd7, 5'd21, 32'd42, "pre_flush");
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd5; op_b = 32'd6; reg_waddr = 5'd22; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        check("flush_no_done", 32'(seen), 32'd0);
        check("flush_res_hold",   result, 32'd42);
        check("flush_waddr_hold", 32'(reg_waddr_o), 32'd21);
        do_op(3'b000, 32'd9, 32'd11, 5'd23, 32'd99, "post_flush");

        // Async reset mid-CALC clears outputs before any clock edge
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd2; op_b = 32'd2; reg_waddr = 5'd24; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #3; rst = 1'b1;
        #1;
        check("arst_busy",  32'(busy), 32'd0);
        check("arst_done",  32'(done), 32'd0);
        check("arst_res",   result, 32'd0);
        check("arst_waddr", 32'(reg_waddr_o), 32'd0);
        @(negedge clk); rst = 1'b0;
        do_op(3'b101, 32'd100, 32'd10, 5'd25, 32'd10, "post_rst");

        // Back-to-back: start held high; second op accepted only from IDLE
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4; reg_waddr = 5'd5; start = 1'b1;
        @(posedge clk); #1;
        funct3 = 3'b000; op_a = 32'd7; op_b = 32'd6; reg_waddr = 5'd6;
        wait_done(edges, bc);
        check("b2b1_lat",   32'(edges + 1), 32'(XLEN + 3));
        check("b2b1_res",   result, 32'd12);
        check("b2b1_waddr", 32'(reg_waddr_o), 32'd5);
        @(posedge clk); #1;
        check("b2b_done_gap_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("b2b_accept_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(edges, bc);
        check("b2b2_busyn", 32'(bc), 32'(XLEN + 2));
        check("b2b2_res",   result, 32'd42);
        check("b2b2_waddr", 32'(reg_waddr_o), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
